// File: rtl/imm_extend_pipe_pkg.sv
// Shared encodings for the registered immediate generator: format selects and
// the skid-buffer occupancy states.
package imm_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } imm_buf_state_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction in, extended immediate out.
interface imm_extend_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [TAG_W-1:0] tag_out;
    logic             imm_err;

    modport master (
        output in_valid, inst, imm_src, tag_in, flush, out_ready,
        input  in_ready, out_valid, imm_out, tag_out, imm_err
    );

    modport slave (
        input  in_valid, inst, imm_src, tag_in, flush, out_ready,
        output in_ready, out_valid, imm_out, tag_out, imm_err
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction/extension for XLEN 32 or 64.
// IMM_ILLEGAL_FMT_EN: format 111 gives zero with err=1; otherwise it decodes as U.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);
    logic [5:0]      shamt;
    logic [XLEN-1:0] imm_u;
    logic            unused_opcode;

    // Opcode bits never feed any immediate.
    assign unused_opcode = ^inst[6:0];

    // RV32 shift amounts are 5 bits; bit 25 belongs to funct7 there.
    assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
    // U is left unshifted; the execute stage applies the << 12.
    assign imm_u = {{(XLEN-20){inst[31]}}, inst[31:12]};

    always_comb begin
        imm = imm_u;
        err = 1'b0;
        unique case (imm_src)
            IMM_I:  imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            IMM_S:  imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:  imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8],
                           1'b0};
            IMM_J:  imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21],
                           1'b0};
            IMM_U:  imm = imm_u;
            IMM_Z:  imm = {{(XLEN-5){1'b0}}, inst[19:15]};
            IMM_SH: imm = {{(XLEN-6){1'b0}}, shamt};
`ifdef IMM_ILLEGAL_FMT_EN
            IMM_RSV: begin
                imm = '0;
                err = 1'b1;
            end
`else
            IMM_RSV: imm = imm_u;
`endif
            default: imm = imm_u;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: decode on input, two-entry skid buffer
// (head + skid) with valid/ready on both sides, flush and sideband tag.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    imm_extend_pipe_if.slave bus
);
    imm_buf_state_t state_q, state_d;
    logic           in_ready_q;
    logic           out_valid;
    logic           push, pop;
    logic           load_head_in, load_head_skid, load_skid;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;
    logic [XLEN-1:0]  head_imm_q, skid_imm_q;
    logic [TAG_W-1:0] head_tag_q, skid_tag_q;
    logic             head_err_q, skid_err_q;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst   (bus.inst),
        .imm_src(bus.imm_src),
        .imm    (dec_imm),
        .err    (dec_err)
    );

    assign out_valid = (state_q != EMPTY);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (push && pop) begin
                        load_head_in = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state, so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_err_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            if (load_head_in) begin
                head_imm_q <= dec_imm;
                head_tag_q <= bus.tag_in;
                head_err_q <= dec_err;
            end else if (load_head_skid) begin
                head_imm_q <= skid_imm_q;
                head_tag_q <= skid_tag_q;
                head_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_tag_q <= bus.tag_in;
                skid_err_q <= dec_err;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.imm_out   = head_imm_q;
    assign bus.tag_out   = head_tag_q;
    assign bus.imm_err   = head_err_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: drives an RV32 and an RV64 instance with the same stimulus.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic [2:0]  imm_src = '0;
    logic [31:0] tag_in = '0;
    logic [31:0] cur_e32 = '0;
    logic [63:0] cur_e64 = '0;
    logic        cur_err = 1'b0;

    imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
    imm_extend_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

    assign b32.in_valid = in_valid;   assign b64.in_valid = in_valid;
    assign b32.inst = inst;           assign b64.inst = inst;
    assign b32.imm_src = imm_src;     assign b64.imm_src = imm_src;
    assign b32.tag_in = tag_in;       assign b64.tag_in = tag_in;
    assign b32.flush = flush;         assign b64.flush = flush;
    assign b32.out_ready = out_ready; assign b64.out_ready = out_ready;

    imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [63:0] e32;
        logic [63:0] e64;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sampled mid-cycle: pops what the DUT is presenting, pushes what it is about to accept.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            check("dut32 out_valid", b32.out_valid, q32.size() != 0);
            check("dut64 out_valid", b64.out_valid, q64.size() != 0);
            if (b32.out_valid && out_ready && q32.size() != 0) begin
                e = q32.pop_front();
                check("dut32 imm_out", b32.imm_out, e.imm);
                check("dut32 tag_out", b32.tag_out, e.tag);
                check("dut32 imm_err", b32.imm_err, e.err);
            end
            if (b64.out_valid && out_ready && q64.size() != 0) begin
                e = q64.pop_front();
                check("dut64 imm_out", b64.imm_out, e.imm);
                check("dut64 tag_out", b64.tag_out, e.tag);
                check("dut64 imm_err", b64.imm_err, e.err);
            end
            if (in_valid && b32.in_ready) q32.push_back('{{32'h0, cur_e32}, tag_in, cur_err});
            if (in_valid && b64.in_ready) q64.push_back('{cur_e64, tag_in, cur_err});
        end
    end

    // Holds the offer until accepted; returns at posedge+1 with cycles taken.
    task automatic offer(input logic [31:0] i, input logic [2:0] s, input logic [31:0] t,
                         input logic [31:0] e32, input logic [63:0] e64, input logic e,
                         output int n);
        logic acc;
        inst = i; imm_src = s; tag_in = t; cur_e32 = e32; cur_e64 = e64; cur_err = e;
        in_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = b32.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("offer accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rsv_e32;
        logic [63:0] rsv_e64;
        logic        rsv_err;

        // Reset state
        idle(2);
        check("reset out_valid", b32.out_valid, 0);
        check("reset imm_out", b32.imm_out, 0);
        check("reset tag_out", b32.tag_out, 0);
        check("reset imm_err", b32.imm_err, 0);
        check("reset out_valid64", b64.out_valid, 0);
        #2 rst_n = 1'b1;
        idle(1);
        check("in_ready after reset", b32.in_ready, 1);

        // Basic I-type, one-cycle latency
        out_ready = 1'b1;
        offer(32'hFFF00093, IMM_I, 32'h1000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, cyc);
        check("t1 out_valid", b32.out_valid, 1);
        check("t1 out_valid64", b64.out_valid, 1);

        // B then I back-to-back at full throughput
        offer(32'hFE000EE3, IMM_B, 32'h1004, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0, cyc);
        check("t2 b cycles", cyc, 1);
        offer(32'h00500093, IMM_I, 32'h1008, 32'h5, 64'h5, 0, cyc);
        check("t2 i cycles", cyc, 1);
        check("t2 out_valid", b32.out_valid, 1);

        // Remaining formats, both widths
        vecs.push_back('{32'hFE112C23, IMM_S, 64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8});
        vecs.push_back('{32'h12345037, IMM_U, 64'h0001_2345, 64'h0001_2345});
        vecs.push_back('{32'h80000037, IMM_U, 64'hFFF8_0000, 64'hFFFF_FFFF_FFF8_0000});
        vecs.push_back('{32'h000FF073, IMM_Z, 64'h1F, 64'h1F});
        vecs.push_back('{32'h03F0D093, IMM_SH, 64'h1F, 64'h3F});
        vecs.push_back('{32'hFFDFF06F, IMM_J, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC});
        foreach (vecs[k])
            offer(vecs[k].inst, vecs[k].src, 32'h2000 + 32'(k) * 4, vecs[k].e32[31:0],
                  vecs[k].e64, 0, cyc);
        idle(3);
        check("formats drained", q32.size(), 0);

        // Backpressure: two accepted, third held until the consumer resumes
        out_ready = 1'b0;
        offer(32'h00100093, IMM_I, 32'd1, 32'h1, 64'h1, 0, cyc);
        offer(32'h00200093, IMM_I, 32'd2, 32'h2, 64'h2, 0, cyc);
        check("t3 in_ready full", b32.in_ready, 0);
        check("t3 in_ready full64", b64.in_ready, 0);
        fork
            offer(32'h00300093, IMM_I, 32'd3, 32'h3, 64'h3, 0, cyc);
            begin
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(4);
        check("t3 drained", q32.size(), 0);
        check("t3 drained64", q64.size(), 0);

        // Flush while FULL with an input offered in the same cycle
        out_ready = 1'b0;
        offer(32'h00400093, IMM_I, 32'h41, 32'h4, 64'h4, 0, cyc);
        offer(32'h00600093, IMM_I, 32'h42, 32'h6, 64'h6, 0, cyc);
        flush = 1'b1;
        in_valid = 1'b1;
        inst = 32'h00700093; imm_src = IMM_I; tag_in = 32'hDEAD;
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4 out_valid", b32.out_valid, 0);
        check("t4 in_ready", b32.in_ready, 1);
        check("t4 out_valid64", b64.out_valid, 0);
        out_ready = 1'b1;
        idle(4);
        check("t4 nothing emerges", b32.out_valid, 0);

        // Asynchronous reset while FULL, then the reserved format
        out_ready = 1'b0;
        offer(32'h00800093, IMM_I, 32'h51, 32'h8, 64'h8, 0, cyc);
        offer(32'hFFF00093, IMM_I, 32'h52, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, cyc);
        check("t6 full", b32.in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        check("t6 async out_valid", b32.out_valid, 0);
        check("t6 async imm_out", b32.imm_out, 0);
        check("t6 async tag_out", b32.tag_out, 0);
        check("t6 async imm_err", b32.imm_err, 0);
        check("t6 async imm_out64", b64.imm_out, 0);
        #3 rst_n = 1'b1;
        idle(1);
        check("t6 in_ready", b32.in_ready, 1);
        out_ready = 1'b1;
`ifdef IMM_ILLEGAL_FMT_EN
        rsv_e32 = 32'h0; rsv_e64 = 64'h0; rsv_err = 1'b1;
`else
        rsv_e32 = 32'hFFF8_0000; rsv_e64 = 64'hFFFF_FFFF_FFF8_0000; rsv_err = 1'b0;
`endif
        offer(32'h80000037, IMM_RSV, 32'h61, rsv_e32, rsv_e64, rsv_err, cyc);
        idle(3);
        check("final drained", q32.size(), 0);
        check("final drained64", q64.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate generator for the decode stage of the pipelined RISC-V core. It extracts and extends the immediate from a 32-bit instruction according to `imm_src`, then holds the result in a two-entry skid buffer with valid/ready handshakes on both sides. Compared with the combinational extender, it adds:
- a configurable datapath width (RV32 or RV64);
- CSR zimm and shift-amount formats;
- a sideband tag (PC) carried alongside each result;
- flush support.

It sits between the fetch/decode register and the ID/EX boundary.

## Interface
- `XLEN`, 32: output immediate width; legal values 32 or 64.
- `TAG_W`, 32: width of the sideband tag carried with each entry.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  an instruction is offered.
- `in_ready`  out  1  the block can accept an instruction this cycle.
- `inst`  in  32  instruction word.
- `imm_src`  in  3  immediate format select.
- `tag_in`  in  TAG_W  sideband value (PC) captured with `inst`.
- `flush`  in  1  synchronous discard of all buffered entries.
- `out_valid`  out  1  `imm_out`, `tag_out` and `imm_err` are valid.
- `out_ready`  in  1  the consumer takes the head entry this cycle.
- `imm_out`  out  XLEN  extended immediate.
- `tag_out`  out  TAG_W  tag of the head entry.
- `imm_err`  out  1  the head entry used the reserved format (see Configuration).

## Operation
Immediate formats. Sign extension always replicates `inst[31]` up to XLEN.
- 000 I: sext(`inst[31:20]`).
- 001 S: sext(`{inst[31:25], inst[11:7]}`).
- 010 B: sext(`{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`).
- 011 J: sext(`{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`).
- 100 U: sext(`inst[31:20+...]`), i.e. sext(`inst[31:12]`), **unshifted**. The downstream datapath applies the shift by 12, as it does today.
- 101 Z: zero-extended `inst[19:15]` (CSR zimm).
- 110 SH: zero-extended `inst[25:20]` when XLEN=64; zero-extended `inst[24:20]` when XLEN=32.
- 111: reserved; see Configuration.

Decode happens on the input side. Each buffer entry stores the already-extended immediate, the tag and the error bit.

Skid buffer state machine (head register plus skid register):
- States are EMPTY, ONE and FULL.
- `in_ready` = (state != FULL), driven from a register.
- `out_valid` = (state != EMPTY).
- A push is `in_valid & in_ready`. A pop is `out_valid & out_ready`.

State transitions:
- EMPTY, push → ONE.
- ONE, push without pop → FULL.
- ONE, pop without push → EMPTY.
- ONE, push and pop → ONE; the head is replaced by the incoming entry.
- FULL, pop → ONE; the skid entry moves to the head. No push is possible while FULL.

Ordering is strictly FIFO.

Flush:
- `flush` dominates push and pop. The next state is EMPTY, and any input presented in the same cycle is dropped.
- Data registers are not cleared on flush, only the valid state.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is presented with `out_valid` high after edge N.
- Throughput is one entry per cycle while `out_ready` stays high.
- `in_ready` depends only on state, with no combinational path from `out_ready`.
- Outputs hold stable while `out_valid & !out_ready`.

Reset (`rst_n` low):
- Takes effect immediately, regardless of `clk` and regardless of any transfer in progress.
- Forces state to EMPTY, `out_valid`=0, `imm_out`=0, `tag_out`=0, `imm_err`=0.
- `in_ready`=1 from the first edge after release.

## Configuration
Macro `IMM_ILLEGAL_FMT_EN` controls how format 111 is handled.
- **Defined:** format 111 yields `imm_out`=0 with `imm_err`=1 stored in the entry. All other formats yield `imm_err`=0.
- **Undefined:** format 111 decodes as U, and `imm_err` is tied to 0.

## Structure
- Package `imm_pkg` holds:
  - the format encoding constants: `IMM_I`, `IMM_S`, `IMM_B`, `IMM_J`, `IMM_U`, `IMM_Z`, `IMM_SH`, `IMM_RSV`;
  - the buffer state typedef `imm_buf_state_t` (EMPTY/ONE/FULL).
- Sub-module `imm_decode` (combinational, parametrised by XLEN) performs format extraction. The top level holds the skid buffer and the FSM.

## Test plan
1. **Basic I-type, XLEN=32.** `inst`=0xFFF00093, `imm_src`=000, `out_ready`=1 → one cycle later `out_valid`=1, `imm_out`=0xFFFFFFFF, `tag_out` equals the tag sent.
2. **B-type back-to-back.** `inst`=0xFE000EE3, src 010, followed by I-type 0x00500093 → `imm_out`=0xFFFFFFFC then 0x00000005 on consecutive cycles, at full throughput.
3. **Backpressure.** `out_ready`=0, offer tags 1, 2, 3 → tags 1 and 2 are accepted, `in_ready`=0 after the second push, and 3 is held. Raise `out_ready` → outputs appear in order 1, 2, 3 with no loss or duplication.
4. **Flush in FULL with simultaneous input.** Assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the offered entry never appears at the output.
5. **XLEN=64 new formats.**
   - Z-type with `inst`=0x000FF073 → `imm_out`=0x1F.
   - SH with 0x03F0D093 → 0x3F.
   - Same SH instruction at XLEN=32 → 0x1F.
   - J-type with negative offset → upper 32 bits all ones.
6. **Reset mid-operation, macro on.** With the buffer FULL, drop `rst_n` between clock edges → outputs are zero immediately. After release, src 111 → `imm_err`=1, `imm_out`=0.
